// File: rtl/cascade_counter_n.sv
// Cascaded up/down counter: STAGES sub-counters of STAGE_W bits acting as one
// TW-bit counter, with clear/load, per-stage carries, wrap pulse and snapshot.
module cascade_counter_n #(
  parameter int STAGE_W = 8,
  parameter int STAGES  = 3,
  localparam int TW     = STAGE_W * STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [TW-1:0]     load_val,
  input  logic              up_dn,
  input  logic              snap_req,
  output logic [TW-1:0]     count,
  output logic [STAGES-1:0] stage_carry,
  output logic              carry_out,
  output logic              wrap,
  output logic [TW-1:0]     snap_data,
  output logic              snap_valid
);

  localparam logic [STAGE_W-1:0] STEP_ONE = STAGE_W'(1);

  logic [TW-1:0]      count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [TW-1:0]      snap_data_q, snap_data_d;
  logic               snap_valid_q, snap_valid_d;

  logic [STAGES-1:0]  stage_step;
  logic [STAGES-1:0]  term_chain;
  logic [STAGES-1:0]  carry_vec;
  logic [TW-1:0]      stepped;
  logic [STAGE_W-1:0] stage_val;
  logic               stage_term;
  logic               below_term;

  // term_chain[i] means stages 0..i all sit at their terminal value, so stage
  // i+1 steps on this edge; every stage updates together, no ripple.
  always_comb begin
    stage_step = '0;
    term_chain = '0;
    stepped    = count_q;
    stage_val  = '0;
    stage_term = 1'b0;
    below_term = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      stage_val     = count_q[i*STAGE_W +: STAGE_W];
      stage_term    = up_dn ? (&stage_val) : (stage_val == '0);
      stage_step[i] = en & below_term;
      if (stage_step[i]) begin
        stepped[i*STAGE_W +: STAGE_W] = up_dn ? (stage_val + STEP_ONE)
                                              : (stage_val - STEP_ONE);
      end
      below_term    = below_term & stage_term;
      term_chain[i] = below_term;
    end
  end

  always_comb begin
    carry_vec = '0;
    if (en && !clr && !load) begin
      carry_vec = term_chain;
    end
  end

  // Clear beats load beats counting; the snapshot takes the pre-update value.
  always_comb begin
    count_d      = stepped;
    wrap_d       = carry_vec[STAGES-1];
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_req;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end
    if (snap_req) begin
      snap_data_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wrap_q       <= 1'b0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign count       = count_q;
  assign stage_carry = carry_vec;
  assign carry_out   = carry_vec[STAGES-1];
  assign wrap        = wrap_q;
  assign snap_data   = snap_data_q;
  assign snap_valid  = snap_valid_q;

endmodule
